execute_stage: RTL

- Y86-64 execute stage, directly downstream of decode_stage; consumes valA/valB from decode plus icode/ifun/valC from fetch.
- Computes valE through the ALU and evaluates the branch/cmov condition Cnd.
- Owns the condition-code register (ZF/SF/OF), the only sequential state in the stage; updated on the clock edge after an OPq.

---
 rtl/execute_stage_pkg.sv | 62 ++++++
 rtl/execute_stage_alu.sv | 45 ++++
 rtl/execute_stage.sv | 83 ++++++++
 3 files changed

// File: rtl/execute_stage_pkg.sv
// Shared Y86-64 encodings for the execute stage: instruction/function codes,
// status codes, condition-code layout and the branch/cmov condition evaluator.
package execute_stage_pkg;

    localparam logic [3:0] I_HALT   = 4'h0;
    localparam logic [3:0] I_NOP    = 4'h1;
    localparam logic [3:0] I_RRMOVQ = 4'h2;
    localparam logic [3:0] I_IRMOVQ = 4'h3;
    localparam logic [3:0] I_RMMOVQ = 4'h4;
    localparam logic [3:0] I_MRMOVQ = 4'h5;
    localparam logic [3:0] I_OPQ    = 4'h6;
    localparam logic [3:0] I_JXX    = 4'h7;
    localparam logic [3:0] I_CALL   = 4'h8;
    localparam logic [3:0] I_RET    = 4'h9;
    localparam logic [3:0] I_PUSHQ  = 4'hA;
    localparam logic [3:0] I_POPQ   = 4'hB;

    localparam logic [3:0] ALU_ADD = 4'h0;
    localparam logic [3:0] ALU_SUB = 4'h1;
    localparam logic [3:0] ALU_AND = 4'h2;
    localparam logic [3:0] ALU_XOR = 4'h3;

    localparam logic [3:0] C_YES = 4'h0;
    localparam logic [3:0] C_LE  = 4'h1;
    localparam logic [3:0] C_L   = 4'h2;
    localparam logic [3:0] C_E   = 4'h3;
    localparam logic [3:0] C_NE  = 4'h4;
    localparam logic [3:0] C_GE  = 4'h5;
    localparam logic [3:0] C_G   = 4'h6;

    localparam logic [2:0] S_AOK = 3'd1;
    localparam logic [2:0] S_HLT = 3'd2;
    localparam logic [2:0] S_ADR = 3'd3;
    localparam logic [2:0] S_INS = 3'd4;

    localparam int CC_ZF = 2;
    localparam int CC_SF = 1;
    localparam int CC_OF = 0;

    // Packed so it maps bit-for-bit onto {ZF,SF,OF}
    typedef struct packed {
        logic zf;
        logic sf;
        logic of;
    } cc_t;

    function automatic logic cond_eval(input logic [3:0] ifun, input cc_t cc);
        logic w_lt;
        w_lt = cc.sf ^ cc.of;
        case (ifun)
            C_YES:   return 1'b1;
            C_LE:    return w_lt | cc.zf;
            C_L:     return w_lt;
            C_E:     return cc.zf;
            C_NE:    return ~cc.zf;
            C_GE:    return ~w_lt;
            C_G:     return ~w_lt & ~cc.zf;
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/execute_stage_alu.sv
// Combinational Y86-64 ALU: result t = aluB op aluA plus the ZF/SF/OF it implies.
module execute_stage_alu
    import execute_stage_pkg::*;
#(
    parameter int DATA_W = 64
) (
    input  logic [DATA_W-1:0] i_alu_a,
    input  logic [DATA_W-1:0] i_alu_b,
    input  logic [3:0]        i_alu_fun,
    output logic [DATA_W-1:0] o_t,
    output logic              o_zf,
    output logic              o_sf,
    output logic              o_of
);

    localparam int MSB = DATA_W - 1;

    logic [DATA_W-1:0] w_t;
    logic              w_of;

    // NOTE: every output of a combinational block gets a default first, so no path can infer a latch.
    always_comb begin
        w_t  = '0;
        w_of = 1'b0;
        case (i_alu_fun)
            ALU_ADD: begin
                w_t  = i_alu_b + i_alu_a;
                w_of = (i_alu_a[MSB] == i_alu_b[MSB]) && (w_t[MSB] != i_alu_a[MSB]);
            end
            ALU_SUB: begin
                w_t  = i_alu_b - i_alu_a;
                w_of = (i_alu_b[MSB] != i_alu_a[MSB]) && (w_t[MSB] != i_alu_b[MSB]);
            end
            ALU_AND: w_t = i_alu_b & i_alu_a;
            ALU_XOR: w_t = i_alu_b ^ i_alu_a;
            default: ;
        endcase
    end

    assign o_t  = w_t;
    assign o_zf = (w_t == '0);
    assign o_sf = w_t[MSB];
    assign o_of = w_of;

endmodule

// File: rtl/execute_stage.sv
// Y86-64 execute stage: operand selection, ALU, the ZF/SF/OF register and the
// branch/cmov condition derived from the registered flags.
module execute_stage
    import execute_stage_pkg::*;
#(
    parameter int         DATA_W = 64,
    parameter logic [2:0] CC_RST = 3'b100
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [3:0]        icode_i,
    input  logic [3:0]        ifun_i,
    input  logic [DATA_W-1:0] valC_i,
    input  logic [DATA_W-1:0] valA_i,
    input  logic [DATA_W-1:0] valB_i,
    input  logic [2:0]        stat_i,
    output logic [DATA_W-1:0] valE_o,
    output logic              Cnd_o,
    output logic [2:0]        cc_o
);

    logic [DATA_W-1:0] w_alu_a;
    logic [DATA_W-1:0] w_alu_b;
    logic [3:0]        w_alu_fun;
    logic              w_set_cc;
    cc_t               w_cc_next;
    cc_t               r_cc;

    always_comb begin
        w_alu_a = '0;
        case (icode_i)
            I_RRMOVQ, I_OPQ:             w_alu_a = valA_i;
            I_IRMOVQ, I_RMMOVQ, I_MRMOVQ: w_alu_a = valC_i;
            I_CALL, I_PUSHQ:             w_alu_a = ~DATA_W'(7);
            I_RET, I_POPQ:               w_alu_a = DATA_W'(8);
            default: ;
        endcase
    end

    always_comb begin
        w_alu_b = '0;
        case (icode_i)
            I_RMMOVQ, I_MRMOVQ, I_OPQ, I_CALL, I_RET, I_PUSHQ, I_POPQ: w_alu_b = valB_i;
            default: ;
        endcase
    end

    assign w_alu_fun = (icode_i == I_OPQ) ? ifun_i : ALU_ADD;

    execute_stage_alu #(
        .DATA_W(DATA_W)
    ) u_alu (
        .i_alu_a   (w_alu_a),
        .i_alu_b   (w_alu_b),
        .i_alu_fun (w_alu_fun),
        .o_t       (valE_o),
        .o_zf      (w_cc_next.zf),
        .o_sf      (w_cc_next.sf),
        .o_of      (w_cc_next.of)
    );

    assign w_set_cc = (icode_i == I_OPQ) && (ifun_i <= ALU_XOR) && (stat_i == S_AOK);

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_cc <= cc_t'(CC_RST);
        end else if (w_set_cc) begin
            r_cc <= w_cc_next;
        end
    end

    // Condition sees the flags from before this instruction's own update
    always_comb begin
        Cnd_o = 1'b0;
        if (icode_i == I_RRMOVQ || icode_i == I_JXX) begin
            Cnd_o = cond_eval(ifun_i, r_cc);
        end
    end

    assign cc_o = r_cc;

endmodule
